// File: rtl/enigma_pkg.sv
// Shared definitions for the enigma plugboard: alphabet constants, ASCII
// letter helpers and the configuration FSM state type.
package enigma_pkg;

    localparam int         ALPHA_SIZE = 26;
    localparam logic [7:0] ASCII_UA   = 8'h41;
    localparam logic [7:0] ASCII_LA   = 8'h61;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE,
        ERR
    } cfg_state_t;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_UA) && (c <= ASCII_UA + 8'd25);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_LA) && (c <= ASCII_LA + 8'd25);
    endfunction

    // Non-letters map to index 0; callers qualify with the letter flags.
    function automatic logic [4:0] to_idx(input logic [7:0] c);
        logic [7:0] off;
        off = 8'd0;
        if (is_upper(c))
            off = c - ASCII_UA;
        else if (is_lower(c))
            off = c - ASCII_LA;
        return off[4:0];
    endfunction

    function automatic logic [7:0] to_ascii(input logic [4:0] idx, input logic upper);
        return (upper ? ASCII_UA : ASCII_LA) + {3'b000, idx};
    endfunction

endpackage

// File: rtl/enigma_plug_table.sv
// Symmetric 26-entry letter swap table: one data-path read port, two lookup
// ports for pair checking and a dual-entry write that installs a->b and b->a.
module enigma_plug_table
    import enigma_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [4:0] rd_idx,
    output logic [4:0] rd_val,
    input  logic [4:0] lk_a_idx,
    output logic [4:0] lk_a_val,
    input  logic [4:0] lk_b_idx,
    output logic [4:0] lk_b_val,
    input  logic       wr_en,
    input  logic [4:0] wr_a,
    input  logic [4:0] wr_b
);

    logic [4:0] tbl [ALPHA_SIZE];

    // Indices past 'Z' never reach a real lookup; answer identity for them.
    assign rd_val   = (rd_idx   < 5'(ALPHA_SIZE)) ? tbl[rd_idx]   : rd_idx;
    assign lk_a_val = (lk_a_idx < 5'(ALPHA_SIZE)) ? tbl[lk_a_idx] : lk_a_idx;
    assign lk_b_val = (lk_b_idx < 5'(ALPHA_SIZE)) ? tbl[lk_b_idx] : lk_b_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ALPHA_SIZE; i++)
                tbl[i] <= 5'(i);
        end else if (clear) begin
            for (int i = 0; i < ALPHA_SIZE; i++)
                tbl[i] <= 5'(i);
        end else if (wr_en) begin
            tbl[wr_a] <= wr_b;
            tbl[wr_b] <= wr_a;
        end
    end

endmodule

// File: rtl/enigma_plugboard.sv
// Plugboard stage ahead of the rotor chain: registered letter substitution
// through a run-time programmable pair table with conflict-checked config.
module enigma_plugboard
    import enigma_pkg::*;
#(
    parameter int MAX_PAIRS = 13,
    parameter int CHAR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic              valid,
    input  logic [CHAR_W-1:0] din,
    output logic [CHAR_W-1:0] dout,
    output logic              done,
    input  logic              cfg_valid,
    input  logic [CHAR_W-1:0] cfg_a,
    input  logic [CHAR_W-1:0] cfg_b,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [3:0]        cfg_pairs
);

    // A byte is only a letter if nothing above the ASCII byte is set.
    function automatic logic fits_byte(input logic [CHAR_W-1:0] c);
        return c == CHAR_W'(c[7:0]);
    endfunction

    cfg_state_t state, state_nxt;

    logic       cfg_accept;
    logic       wr_en;
    logic       reject;
    logic [3:0] pair_cnt;
    logic [4:0] a_idx, b_idx;
    logic       a_ltr, b_ltr;
    logic [4:0] lk_a_val, lk_b_val;

    logic       din_up, din_lw;
    logic [4:0] din_idx, map_idx;
    logic [7:0] sub_char;

    logic [CHAR_W-1:0] data_p0;
    logic              vld_p0;

    enigma_plug_table u_table (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .rd_idx   (din_idx),
        .rd_val   (map_idx),
        .lk_a_idx (a_idx),
        .lk_a_val (lk_a_val),
        .lk_b_idx (b_idx),
        .lk_b_val (lk_b_val),
        .wr_en    (wr_en),
        .wr_a     (a_idx),
        .wr_b     (b_idx)
    );

    // ---- data path: table lookup feeding the single output register ----
    always_comb begin
        din_up   = fits_byte(din) && is_upper(din[7:0]);
        din_lw   = fits_byte(din) && is_lower(din[7:0]);
        din_idx  = to_idx(din[7:0]);
        sub_char = to_ascii(map_idx, din_up);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= valid && en;
            if (valid && en)
                data_p0 <= (din_up || din_lw) ? CHAR_W'(sub_char) : din;
        end
    end

    assign dout = data_p0;
    assign done = vld_p0;

    // ---- config FSM: state register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign reject = !a_ltr || !b_ltr || (a_idx == b_idx) ||
                    (lk_a_val != a_idx) || (lk_b_val != b_idx) ||
                    (pair_cnt == 4'(MAX_PAIRS));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_valid) state_nxt = CHECK;
            CHECK:   state_nxt = reject ? ERR : WRITE;
            WRITE:   state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear)
            state_nxt = IDLE;
    end

    always_comb begin
        cfg_ready  = (state == IDLE);
        cfg_err    = (state == ERR);
        cfg_accept = (state == IDLE) && cfg_valid && !clear;
        wr_en      = (state == WRITE) && !clear;
    end

    // ---- config capture: normalised letter indices for CHECK/WRITE ----
    always_ff @(posedge clk) begin
        if (cfg_accept) begin
            a_idx <= to_idx(cfg_a[7:0]);
            b_idx <= to_idx(cfg_b[7:0]);
            a_ltr <= fits_byte(cfg_a) && (is_upper(cfg_a[7:0]) || is_lower(cfg_a[7:0]));
            b_ltr <= fits_byte(cfg_b) && (is_upper(cfg_b[7:0]) || is_lower(cfg_b[7:0]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pair_cnt <= 4'd0;
        else if (clear)
            pair_cnt <= 4'd0;
        else if (wr_en)
            pair_cnt <= pair_cnt + 4'd1;
    end

    assign cfg_pairs = pair_cnt;

endmodule

// File: tb/tb_enigma_plugboard.sv
// Scoreboard bench for enigma_plugboard: a driver pushes expected results from
// an array-based plugboard model, a negedge monitor pops and compares.
module tb_enigma_plugboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       done;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_a = 8'h00;
    logic [7:0] cfg_b = 8'h00;
    logic       cfg_ready;
    logic       cfg_err;
    logic [3:0] cfg_pairs;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit err;
        int pairs;
    } cfg_exp_t;

    logic [7:0] data_q [$];
    cfg_exp_t   cfg_q [$];

    int         map [26];
    int         npairs;
    logic [7:0] last_dout = 8'h00;

    always #5 clk = ~clk;

    enigma_plugboard #(.MAX_PAIRS(13), .CHAR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .en        (en),
        .valid     (valid),
        .din       (din),
        .dout      (dout),
        .done      (done),
        .cfg_valid (cfg_valid),
        .cfg_a     (cfg_a),
        .cfg_b     (cfg_b),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cfg_pairs (cfg_pairs)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---- reference plugboard ----
    function automatic bit is_up(input logic [7:0] c);
        return c >= "A" && c <= "Z";
    endfunction

    function automatic bit is_lo(input logic [7:0] c);
        return c >= "a" && c <= "z";
    endfunction

    function automatic int letter_num(input logic [7:0] c);
        return is_up(c) ? int'(c - "A") : int'(c - "a");
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 26; i++) map[i] = i;
        npairs = 0;
    endtask

    function automatic logic [7:0] model_char(input logic [7:0] c);
        if (is_up(c)) return 8'h41 + 8'(map[letter_num(c)]);
        if (is_lo(c)) return 8'h61 + 8'(map[letter_num(c)]);
        return c;
    endfunction

    task automatic model_cfg(input logic [7:0] a, input logic [7:0] b, output bit err);
        int ia, ib;
        err = 1'b0;
        if (!(is_up(a) || is_lo(a)) || !(is_up(b) || is_lo(b))) begin
            err = 1'b1;
            return;
        end
        ia = letter_num(a);
        ib = letter_num(b);
        if (ia == ib || map[ia] != ia || map[ib] != ib || npairs >= 13) begin
            err = 1'b1;
            return;
        end
        map[ia] = ib;
        map[ib] = ia;
        npairs++;
    endtask

    // ---- driver primitives (driver always sits 1ns after a rising edge) ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c, input bit v, input bit e);
        valid = v;
        en = e;
        din = c;
        if (v && e) begin
            last_dout = model_char(c);
            data_q.push_back(last_dout);
        end
        step();
        valid = 1'b0;
        en = 1'b0;
    endtask

    task automatic cfg_pair(input logic [7:0] a, input logic [7:0] b);
        int cyc;
        cfg_exp_t ex;
        bit err;
        cyc = 0;
        while (!cfg_ready && cyc < 20) begin
            step();
            cyc++;
        end
        if (!cfg_ready) begin
            check("cfg_ready_timeout", 0, 1);
            return;
        end
        cfg_valid = 1'b1;
        cfg_a = a;
        cfg_b = b;
        model_cfg(a, b, err);
        ex.err = err;
        ex.pairs = npairs;
        cfg_q.push_back(ex);
        step();
        cfg_valid = 1'b0;
        step();
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        check("pairs_after_clear", 32'(cfg_pairs), 0);
    endtask

    function automatic logic [7:0] rnd_letter();
        return ($urandom_range(0, 1) ? 8'h41 : 8'h61) + 8'($urandom_range(0, 25));
    endfunction

    function automatic logic [7:0] rnd_byte();
        if ($urandom_range(0, 9) < 7) return rnd_letter();
        return 8'($urandom);
    endfunction

    // ---- monitor: compare whatever the DUT presents against the queues ----
    initial begin
        bit prev_ready = 1'b1;
        bit prev_err = 1'b0;
        logic [7:0] exp_c;
        cfg_exp_t ex;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ready = 1'b1;
                prev_err = 1'b0;
            end else begin
                if (done) begin
                    if (data_q.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        exp_c = data_q.pop_front();
                        check("dout", 32'(dout), 32'(exp_c));
                    end
                end
                if (cfg_ready && !prev_ready) begin
                    if (cfg_q.size() == 0) begin
                        check("cfg_unexpected", 1, 0);
                    end else begin
                        ex = cfg_q.pop_front();
                        check("cfg_err_pulse", 32'(prev_err), 32'(ex.err));
                        check("cfg_pairs", 32'(cfg_pairs), 32'(ex.pairs));
                    end
                end
                prev_ready = cfg_ready;
                prev_err = cfg_err;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---- stimulus ----
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_pairs", 32'(cfg_pairs), 0);
        reset = 1'b0;
        step();

        send_char("Q", 1, 1);
        check("idle_ready", 32'(cfg_ready), 1);
        check("idle_pairs", 32'(cfg_pairs), 0);

        cfg_pair("A", "z");
        send_char("A", 1, 1);
        send_char("z", 1, 1);
        send_char("m", 1, 1);
        send_char("5", 1, 1);

        do_clear();
        cfg_pair("A", "B");
        cfg_pair("a", "C");
        send_char("C", 1, 1);
        send_char("A", 1, 1);

        cfg_pair("D", "d");
        cfg_pair("D", "#");
        send_char("D", 1, 1);

        // clear, a config request and a character all on one edge
        valid = 1'b1;
        en = 1'b1;
        din = "E";
        last_dout = model_char("E");
        data_q.push_back(last_dout);
        clear = 1'b1;
        cfg_valid = 1'b1;
        cfg_a = "E";
        cfg_b = "F";
        step();
        valid = 1'b0;
        en = 1'b0;
        clear = 1'b0;
        cfg_valid = 1'b0;
        model_reset();
        check("clear_pairs", 32'(cfg_pairs), 0);
        check("clear_ready", 32'(cfg_ready), 1);
        send_char("A", 1, 1);
        send_char("b", 1, 1);

        for (int i = 0; i < 13; i++)
            cfg_pair(8'h41 + 8'(i), 8'h61 + 8'(i + 13));
        cfg_pair("A", "n");
        send_char("N", 1, 1);
        send_char("g", 1, 1);

        send_char("A", 1, 0);
        check("en0_done", 32'(done), 0);
        check("en0_dout_hold", 32'(dout), 32'(last_dout));

        // reset while the FSM sits in CHECK
        cfg_valid = 1'b1;
        cfg_a = "G";
        cfg_b = "H";
        step();
        cfg_valid = 1'b0;
        check("in_check_ready", 32'(cfg_ready), 0);
        reset = 1'b1;
        #1;
        check("mid_rst_dout", 32'(dout), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_err", 32'(cfg_err), 0);
        check("mid_rst_ready", 32'(cfg_ready), 1);
        check("mid_rst_pairs", 32'(cfg_pairs), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        last_dout = 8'h00;
        step();
        check("post_rst_ready", 32'(cfg_ready), 1);
        send_char("N", 1, 1);
        cfg_pair("G", "H");

        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                cfg_pair(rnd_byte(), rnd_byte());
            end else if (r == 3) begin
                do_clear();
            end else begin
                int n;
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++)
                    send_char(rnd_byte(), $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
            end
        end

        repeat (4) step();
        check("data_q_drained", 32'(data_q.size()), 0);
        check("cfg_q_drained", 32'(cfg_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enigma_plugboard.md
Name: enigma_plugboard

Overview:
- Plugboard (Steckerbrett) stage directly upstream of the enigma rotor chain.
- Swaps ASCII letters through a programmable, symmetric 26-entry pair table.
- Its registered valid/data output feeds the first rotor's `valid`/`din`.
- Pairs are loaded at run time through a small configuration handshake with conflict checking.

Parameters:
- MAX_PAIRS, 13, maximum number of accepted swap pairs (26 letters / 2)
- CHAR_W, 8, width of the character bus (ASCII)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- clear  in  1  synchronous: restore identity table, zero pair count, abort config
- en  in  1  data-path enable
- valid  in  1  input character strobe
- din  in  CHAR_W  ASCII input character
- dout  out  CHAR_W  substituted character, registered
- done  out  1  dout valid strobe, registered
- cfg_valid  in  1  config pair request
- cfg_a  in  CHAR_W  first letter of pair (upper or lower case)
- cfg_b  in  CHAR_W  second letter of pair
- cfg_ready  out  1  config FSM can accept a pair
- cfg_err  out  1  one-cycle pulse: last pair rejected
- cfg_pairs  out  4  number of accepted pairs

Behaviour:
Interface:
- One clock `clk`; reset `reset` is asynchronous, active-high.

Reset (also on assertion mid-operation, aborting everything in flight):
- Table is identity (entry i = i).
- Pair count is 0, FSM is IDLE.
- dout=8'h00, done=0, cfg_err=0, cfg_ready=1, cfg_pairs=0.

Data path (latency 1 cycle, no backpressure):
- On an edge with valid=1 and en=1: done<=1.
- If din is 'A'..'Z': dout<='A'+table[din-'A'].
- If din is 'a'..'z': dout<='a'+table[din-'a']. Case is preserved.
- Any other byte passes through unchanged.
- With valid=0 or en=0: done<=0 and dout holds its value.
- The table is read with its pre-edge contents, so a WRITE or clear on the same edge affects only later characters.

Config FSM: IDLE -> CHECK -> (WRITE | ERR) -> IDLE.
- IDLE: cfg_ready=1. On cfg_valid=1 and clear=0, capture cfg_a/cfg_b normalised to index 0..25 plus per-letter "is letter" flags, then go to CHECK.
- CHECK (1 cycle): the pair is rejected if any of these holds:
  - either byte is a non-letter;
  - a==b (case-insensitive);
  - table[a]!=a or table[b]!=b (letter already plugged);
  - count==MAX_PAIRS.
  Go to ERR on reject, else WRITE.
- WRITE (1 cycle): table[a]<=b, table[b]<=a, count<=count+1. Go to IDLE.
- ERR (1 cycle): cfg_err=1, table and count unchanged. Go to IDLE.
- Handshake accepted at edge T: CHECK during T+1, WRITE/ERR during T+2, cfg_ready=1 again at T+3.
- Request throughput is one pair per 3 cycles.
- cfg_ready=0 outside IDLE. cfg_valid is ignored while cfg_ready=0.

Clear:
- clear=1 at an edge: identity table, count=0, FSM to IDLE, cfg_err=0.
- Clear wins over a simultaneous cfg_valid or WRITE; that pair is dropped.
- Clear does not affect done/dout for a character accepted on the same edge.

Invariants:
- The table is always an involution.
- cfg_pairs equals the number of non-identity entries divided by 2.
- count never exceeds MAX_PAIRS.
  - With 13 pairs every letter is plugged, so any further pair fails the "already plugged" check.
  - The count check is kept as an explicit guard.

Decomposition:
- Shared package enigma_pkg:
  - ALPHA_SIZE=26, ASCII_UA=8'h41, ASCII_LA=8'h61.
  - Functions is_upper, is_lower, to_idx (byte -> 5-bit index), to_ascii (index + case -> byte).
  - cfg_state enum {IDLE, CHECK, WRITE, ERR}.
- Sub-module enigma_plug_table:
  - 26x5-bit register array with asynchronous reset to identity and synchronous clear.
  - One combinational read port for the data path.
  - Two combinational lookup ports for CHECK.
  - One dual-entry write port (a->b, b->a).
- The top level holds the FSM, the pair counter and the output registers.

Test Plan:
- Reset, then valid with 'Q' and en=1:
  - Next cycle: done=1, dout='Q'.
  - cfg_ready=1, cfg_pairs=0.
- Program the pair ('A','z'), then send 'A', 'z', 'm', '5' on consecutive cycles:
  - dout sequence is 'Z', 'a', 'm', '5'.
  - done is high for 4 cycles; cfg_pairs=1.
- Program ('A','B'), then ('a','C'):
  - The second request gets a cfg_err pulse exactly 2 cycles after acceptance.
  - cfg_pairs stays 1; 'C' -> 'C', 'A' -> 'B'.
- Rejected pairs ('D','d') and ('D','#'):
  - Each produces cfg_err with the table unchanged.
  - Apply 13 disjoint pairs, then a 14th: cfg_pairs=13, cfg_err=1.
- Assert clear together with cfg_valid ('E','F') while 'E' is sent with valid:
  - dout='E' (original table).
  - Pair dropped; cfg_pairs=0.
  - Previously plugged letters map to themselves afterwards.
- en=0 with valid=1 carrying 'A':
  - done=0 and dout holds its previous value.
- Assert reset during CHECK:
  - All outputs return to reset values immediately.
  - The FSM is in IDLE after release.
